// File: rtl/change_dispenser_if.sv
// Signal bundle between the change dispenser (slave side) and the controller
// plus coin-ejection mechanism that drive it (master side).
interface change_dispenser_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic [WIDTH-1:0] change;
    logic             coinAck;
    logic             coinReq;
    logic [1:0]       coinSel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] coinCount;
    logic [WIDTH-1:0] remaining;
    logic             fault;

    modport slave (
        input  start,
        input  change,
        input  coinAck,
        output coinReq,
        output coinSel,
        output busy,
        output done,
        output coinCount,
        output remaining,
        output fault
    );

    modport master (
        output start,
        output change,
        output coinAck,
        input  coinReq,
        input  coinSel,
        input  busy,
        input  done,
        input  coinCount,
        input  remaining,
        input  fault
    );
endinterface

// File: rtl/change_dispenser.sv
// Pays out a latched change amount one coin at a time using greedy denomination
// selection and a four-phase req/ack handshake, with a sticky ack-timeout fault.
module change_dispenser #(
    parameter int WIDTH       = 5,
    parameter int D0_VAL      = 10,
    parameter int D1_VAL      = 5,
    parameter int D2_VAL      = 2,
    parameter int D3_VAL      = 1,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               reset,
    change_dispenser_if.slave  bus
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0]    TIMER_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [WIDTH-1:0] V0 = WIDTH'(D0_VAL);
    localparam logic [WIDTH-1:0] V1 = WIDTH'(D1_VAL);
    localparam logic [WIDTH-1:0] V2 = WIDTH'(D2_VAL);
    localparam logic [WIDTH-1:0] V3 = WIDTH'(D3_VAL);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_REQ,
        ST_GAP,
        ST_DONE,
        ST_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic             start_q, start_d;
    logic [WIDTH-1:0] change_q, change_d;
    logic             coin_req_q, coin_req_d;
    logic [1:0]       coin_sel_q, coin_sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             fault_q, fault_d;
    logic [TW-1:0]    timer_q, timer_d;

    function automatic logic [1:0] pick_coin(input logic [WIDTH-1:0] amt);
        if (amt >= V0)      return 2'd0;
        else if (amt >= V1) return 2'd1;
        else if (amt >= V2) return 2'd2;
        else                return 2'd3;
    endfunction

    function automatic logic [WIDTH-1:0] coin_value(input logic [1:0] sel);
        case (sel)
            2'd0:    return V0;
            2'd1:    return V1;
            2'd2:    return V2;
            default: return V3;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            change_q    <= '0;
            coin_req_q  <= 1'b0;
            coin_sel_q  <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            remaining_q <= '0;
            fault_q     <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            change_q    <= change_d;
            coin_req_q  <= coin_req_d;
            coin_sel_q  <= coin_sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            fault_q     <= fault_d;
            timer_q     <= timer_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_d     = 1'b0;
        change_d    = change_q;
        coin_sel_d  = coin_sel_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        timer_d     = timer_q;

        // start and change are captured only while idle; the capture register adds one cycle
        // before SELECT so a start at edge N reaches SELECT at N+1.
        if (state_q == ST_IDLE && bus.start) begin
            start_d  = 1'b1;
            change_d = bus.change;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_q) begin
                    remaining_d = change_q;
                    count_d     = '0;
                    state_d     = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (remaining_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    coin_sel_d = pick_coin(remaining_q);
                    timer_d    = '0;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.coinAck) begin
                    remaining_d = remaining_q - coin_value(coin_sel_q);
                    count_d     = count_q + WIDTH'(1);
                    state_d     = ST_GAP;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_GAP: begin
                if (!bus.coinAck) begin
                    state_d = ST_SELECT;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state register.
        coin_req_d = (state_d == ST_REQ);
        busy_d     = (state_d != ST_IDLE) && (state_d != ST_FAULT);
        done_d     = (state_d == ST_DONE);
        fault_d    = fault_q || (state_d == ST_FAULT);
    end

    assign bus.coinReq   = coin_req_q;
    assign bus.coinSel   = coin_sel_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.coinCount = count_q;
    assign bus.remaining = remaining_q;
    assign bus.fault     = fault_q;

    a_sel_stable: assert property (@(posedge clk) disable iff (reset)
        (coin_req_q && !bus.coinAck && timer_q != TIMER_LAST) |=> (coin_req_q && $stable(coin_sel_q)));
    a_done_pulse: assert property (@(posedge clk) disable iff (reset) done_q |=> !done_q);
    a_fault_sticky: assert property (@(posedge clk) disable iff (reset) fault_q |=> fault_q);

endmodule
